// File: rtl/snn_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// snn_ctrl_pkg
// Shared definitions for the spiking-network time-step controller:
//   - state_t        : controller FSM states
//   - DEF_*          : default values for the controller parameters
//   - STEP_W/PHASE_W : widths of the step counter and the in-phase cycle counter
//   - isRunPhase     : states in which network output spikes are counted
//   - isAcceptPhase  : states in which upstream spike requests may be taken
// ---------------------------------------------------------------------------
package snn_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_FIRE    = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam int DEF_N_IN           = 3;
   localparam int DEF_N_OUT          = 2;
   localparam int DEF_N_W            = 5;
   localparam int DEF_COLLECT_CYCLES = 8;
   localparam int DEF_SETTLE_CYCLES  = 4;
   localparam int DEF_CNT_W          = 8;

   localparam int STEP_W  = 16;
   localparam int PHASE_W = 16;

   // A run covers the three per-step phases; IDLE and DONE are outside it.
   function automatic logic isRunPhase(input state_t s);
      return (s == ST_COLLECT) || (s == ST_FIRE) || (s == ST_SETTLE);
   endfunction

   // Spike slots are open everywhere in a step except the FIRE cycle, where
   // they are being drained into the network.
   function automatic logic isAcceptPhase(input state_t s);
      return (s == ST_COLLECT) || (s == ST_SETTLE);
   endfunction

endpackage

// File: rtl/snn_spike_slot.sv
// ---------------------------------------------------------------------------
// snn_spike_slot
// One-entry valid/ready holding register for a single input channel. A spike
// (with its sign) is captured when i_valid meets o_ready and held until
// i_clear empties the slot.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_enable       : slot may accept in this cycle
//   i_valid/i_sign : upstream request and its sign
//   i_clear        : drop the held entry at the end of this cycle
//   o_ready        : slot is empty and enabled
//   o_nextFull     : slot holds a spike, or is taking one this cycle
//   o_nextSign     : sign belonging to o_nextFull
// ---------------------------------------------------------------------------
module snn_spike_slot (
   input  logic clk,
   input  logic rst_n,
   input  logic i_enable,
   input  logic i_valid,
   input  logic i_sign,
   input  logic i_clear,
   output logic o_ready,
   output logic o_nextFull,
   output logic o_nextSign
);

   logic r_full;
   logic r_sign;
   logic w_accept;

   assign o_ready  = i_enable & ~r_full;
   assign w_accept = i_valid & o_ready;

   // The slot holds at most one spike; a held spike blocks the channel until
   // the controller clears it after firing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_sign <= 1'b0;
      end else if (i_clear) begin
         r_full <= 1'b0;
         r_sign <= 1'b0;
      end else if (w_accept) begin
         r_full <= 1'b1;
         r_sign <= i_sign;
      end
   end

   // Look-ahead view lets the controller register a spike taken in the very
   // last collect cycle into the fire pulse.
   assign o_nextFull = r_full | w_accept;
   assign o_nextSign = w_accept ? i_sign : (r_full & r_sign);

endmodule

// File: rtl/snn_step_controller.sv
// ---------------------------------------------------------------------------
// snn_step_controller
// Time-step sequencer for the 3-input/2-output spiking network. Buffers one
// spike request per input channel, fires all buffered spikes as a one-cycle
// pulse per time step, applies weight updates only at step boundaries and
// counts network output spikes over a run of a programmed number of steps.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start, stop, num_steps   : run control (num_steps = 0 runs until stop)
//   spike_valid/sign/ready   : per-channel spike request handshake
//   cfg_valid/weight/ready   : weight update handshake into the shadow
//   data_in, sign_in, weight : drive to the network
//   out_data                 : network output spikes
//   spike_cnt                : per-output saturating counts, output 0 in LSBs
//   step_count               : completed steps of the current/last run
//   busy, done               : outside IDLE / one-cycle end-of-run pulse
// ---------------------------------------------------------------------------
module snn_step_controller
   import snn_ctrl_pkg::*;
#(
   parameter int             N_IN           = DEF_N_IN,
   parameter int             N_OUT          = DEF_N_OUT,
   parameter int             N_W            = DEF_N_W,
   parameter int             COLLECT_CYCLES = DEF_COLLECT_CYCLES,
   parameter int             SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int             CNT_W          = DEF_CNT_W,
   parameter logic [N_W-1:0] WEIGHT_RST     = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic [STEP_W-1:0]      num_steps,
   input  logic [N_IN-1:0]        spike_valid,
   input  logic [N_IN-1:0]        spike_sign,
   output logic [N_IN-1:0]        spike_ready,
   input  logic                   cfg_valid,
   input  logic [N_W-1:0]         cfg_weight,
   output logic                   cfg_ready,
   output logic [N_IN-1:0]        data_in,
   output logic [N_IN-1:0]        sign_in,
   output logic [N_W-1:0]         weight,
   input  logic [N_OUT-1:0]       out_data,
   output logic [N_OUT*CNT_W-1:0] spike_cnt,
   output logic [STEP_W-1:0]      step_count,
   output logic                   busy,
   output logic                   done
);

   state_t              r_state;
   state_t              w_nextState;
   logic [PHASE_W-1:0]  r_phaseCnt;
   logic [STEP_W-1:0]   r_stepCount;
   logic [STEP_W-1:0]   r_numSteps;
   logic [STEP_W-1:0]   w_newStepCount;
   logic                r_stopFlag;
   logic                w_runStart;
   logic                w_phaseLast;
   logic                w_runEnd;
   logic                w_fireNext;

   logic [N_IN-1:0]     w_slotReady;
   logic [N_IN-1:0]     w_slotNextFull;
   logic [N_IN-1:0]     w_slotNextSign;
   logic                w_slotEnable;
   logic                w_slotClear;
   logic [N_IN-1:0]     r_dataIn;
   logic [N_IN-1:0]     r_signIn;

   logic [N_W-1:0]      r_shadow;
   logic                r_shadowFull;
   logic [N_W-1:0]      r_weight;
   logic                w_cfgAccept;
   logic                w_weightCopy;

   logic [CNT_W-1:0]    r_spikeCnt [N_OUT];
   logic                r_busy;
   logic                r_done;

   assign w_runStart     = (r_state == ST_IDLE) && start;
   assign w_newStepCount = r_stepCount + 16'd1;

   // Each timed phase ends when its cycle counter reaches the programmed
   // length; the counter restarts on every state change.
   always_comb begin
      w_phaseLast = 1'b0;
      if (r_state == ST_COLLECT)
         w_phaseLast = (r_phaseCnt == PHASE_W'(COLLECT_CYCLES - 1));
      else if (r_state == ST_SETTLE)
         w_phaseLast = (r_phaseCnt == PHASE_W'(SETTLE_CYCLES - 1));
   end

   // A stop raised during the final settle cycle still ends the run after
   // this step, so the live input is merged with the sticky flag.
   assign w_runEnd = r_stopFlag | stop |
                     ((r_numSteps != '0) && (w_newStepCount == r_numSteps));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_nextState;
   end

   // Next-state logic for the step sequence.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:    if (start) w_nextState = ST_COLLECT;
         ST_COLLECT: if (w_phaseLast) w_nextState = ST_FIRE;
         ST_FIRE:    w_nextState = ST_SETTLE;
         ST_SETTLE:  if (w_phaseLast) w_nextState = w_runEnd ? ST_DONE : ST_COLLECT;
         ST_DONE:    w_nextState = ST_IDLE;
         default:    w_nextState = ST_IDLE;
      endcase
   end

   // Cycle counter within COLLECT and SETTLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_phaseCnt <= '0;
      else if (w_nextState != r_state)
         r_phaseCnt <= '0;
      else if (isAcceptPhase(r_state))
         r_phaseCnt <= r_phaseCnt + 1'b1;
   end

   // Run bookkeeping: step count, latched step target and sticky stop flag.
   // Counters are cleared only by a new start so they stay readable after DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stepCount <= '0;
         r_numSteps  <= '0;
         r_stopFlag  <= 1'b0;
      end else if (w_runStart) begin
         r_stepCount <= '0;
         r_numSteps  <= num_steps;
         r_stopFlag  <= 1'b0;
      end else begin
         if ((r_state == ST_SETTLE) && w_phaseLast)
            r_stepCount <= w_newStepCount;
         if (r_state == ST_DONE)
            r_stopFlag <= 1'b0;
         else if (stop && (r_state != ST_IDLE))
            r_stopFlag <= 1'b1;
      end
   end

   assign w_slotEnable = isAcceptPhase(r_state);
   assign w_slotClear  = (r_state == ST_FIRE);

   for (genvar i = 0; i < N_IN; i++) begin : gSlot
      snn_spike_slot uSlot (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_enable   (w_slotEnable),
         .i_valid    (spike_valid[i]),
         .i_sign     (spike_sign[i]),
         .i_clear    (w_slotClear),
         .o_ready    (w_slotReady[i]),
         .o_nextFull (w_slotNextFull[i]),
         .o_nextSign (w_slotNextSign[i])
      );
   end

   assign w_fireNext = (r_state == ST_COLLECT) && (w_nextState == ST_FIRE);

   // Fire pulse registers: loaded on the edge into FIRE, so the pulse lines
   // up exactly with the FIRE cycle and is zero in every other cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dataIn <= '0;
         r_signIn <= '0;
      end else if (w_fireNext) begin
         r_dataIn <= w_slotNextFull;
         r_signIn <= w_slotNextFull & w_slotNextSign;
      end else begin
         r_dataIn <= '0;
         r_signIn <= '0;
      end
   end

   assign w_cfgAccept  = cfg_valid & ~r_shadowFull;
   assign w_weightCopy = r_shadowFull && ((r_state == ST_FIRE) || (r_state == ST_IDLE));

   // Weight shadow. The copy happens at the end of FIRE, so the new weight
   // first appears in SETTLE and never coincides with a fire pulse. In IDLE
   // no pulses exist and the copy follows acceptance directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow     <= '0;
         r_shadowFull <= 1'b0;
         r_weight     <= WEIGHT_RST;
      end else if (w_weightCopy) begin
         r_weight     <= r_shadow;
         r_shadowFull <= 1'b0;
      end else if (w_cfgAccept) begin
         r_shadow     <= cfg_weight;
         r_shadowFull <= 1'b1;
      end
   end

   // Saturating per-output spike counters, active only inside a run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < N_OUT; j++) r_spikeCnt[j] <= '0;
      end else if (w_runStart) begin
         for (int j = 0; j < N_OUT; j++) r_spikeCnt[j] <= '0;
      end else if (isRunPhase(r_state)) begin
         for (int j = 0; j < N_OUT; j++)
            if (out_data[j] && (r_spikeCnt[j] != {CNT_W{1'b1}}))
               r_spikeCnt[j] <= r_spikeCnt[j] + 1'b1;
      end
   end

   // Status flags are registered from the next state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_nextState != ST_IDLE);
         r_done <= (w_nextState == ST_DONE);
      end
   end

   for (genvar j = 0; j < N_OUT; j++) begin : gCnt
      assign spike_cnt[j*CNT_W +: CNT_W] = r_spikeCnt[j];
   end

   // spike_ready decodes flops only (state and slot occupancy), so it carries
   // no combinational path from any input.
   assign spike_ready = w_slotReady;
   assign cfg_ready   = ~r_shadowFull;
   assign data_in     = r_dataIn;
   assign sign_in     = r_signIn;
   assign weight      = r_weight;
   assign step_count  = r_stepCount;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_snn_step_controller.sv
// ---------------------------------------------------------------------------
// tb_snn_step_controller
// Directed bench for snn_step_controller. Stimulus tasks push the expected
// fire pulses and done pulses into queues; a monitor on the falling edge pops
// and compares whenever the DUT shows a pulse. Static expectations (reset
// values, counters, weight timing) are compared directly.
// ---------------------------------------------------------------------------
module tb_snn_step_controller;

   localparam int N_IN  = 3;
   localparam int N_OUT = 2;
   localparam int N_W   = 5;
   localparam int CNT_W = 8;
   localparam int COLL  = 8;
   localparam int SETL  = 4;
   localparam int STEP  = COLL + 1 + SETL;

   typedef struct {
      logic [N_IN-1:0] data;
      logic [N_IN-1:0] sign;
      logic [N_W-1:0]  weight;
      int              cycle;
   } fireExp_t;

   typedef struct {
      int stepCount;
      int cycle;
   } doneExp_t;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic                   stop = 1'b0;
   logic [15:0]            num_steps = '0;
   logic [N_IN-1:0]        spike_valid = '0;
   logic [N_IN-1:0]        spike_sign = '0;
   logic [N_IN-1:0]        spike_ready;
   logic                   cfg_valid = 1'b0;
   logic [N_W-1:0]         cfg_weight = '0;
   logic                   cfg_ready;
   logic [N_IN-1:0]        data_in;
   logic [N_IN-1:0]        sign_in;
   logic [N_W-1:0]         weight;
   logic [N_OUT-1:0]       out_data = '0;
   logic [N_OUT*CNT_W-1:0] spike_cnt;
   logic [15:0]            step_count;
   logic                   busy;
   logic                   done;

   int       cycleNum = 0;
   int       numChecks = 0;
   int       numFails = 0;
   fireExp_t fireQ [$];
   doneExp_t doneQ [$];

   snn_step_controller #(
      .N_IN(N_IN), .N_OUT(N_OUT), .N_W(N_W), .COLLECT_CYCLES(COLL),
      .SETTLE_CYCLES(SETL), .CNT_W(CNT_W), .WEIGHT_RST(5'b00000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .num_steps(num_steps),
      .spike_valid(spike_valid), .spike_sign(spike_sign), .spike_ready(spike_ready),
      .cfg_valid(cfg_valid), .cfg_weight(cfg_weight), .cfg_ready(cfg_ready),
      .data_in(data_in), .sign_in(sign_in), .weight(weight), .out_data(out_data),
      .spike_cnt(spike_cnt), .step_count(step_count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleNum <= cycleNum + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cycleNum);
      end
   endtask

   // Scoreboard monitor: every fire pulse and every done pulse must match the
   // oldest outstanding expectation.
   always @(negedge clk) begin
      fireExp_t fe;
      doneExp_t de;
      if (rst_n) begin
         if ((data_in != '0) || (sign_in != '0)) begin
            if (fireQ.size() == 0) begin
               numChecks++;
               numFails++;
               $display("[TB] FAIL unexpected_fire: data_in=%b sign_in=%b at cycle %0d, none required", data_in, sign_in, cycleNum);
            end else begin
               fe = fireQ.pop_front();
               checkOutput("fire_data", 32'(data_in), 32'(fe.data));
               checkOutput("fire_sign", 32'(sign_in), 32'(fe.sign));
               checkOutput("fire_weight", 32'(weight), 32'(fe.weight));
               checkOutput("fire_cycle", cycleNum, fe.cycle);
            end
         end
         if (done) begin
            if (doneQ.size() == 0) begin
               numChecks++;
               numFails++;
               $display("[TB] FAIL unexpected_done: step_count=%0d at cycle %0d, none required", step_count, cycleNum);
            end else begin
               de = doneQ.pop_front();
               checkOutput("done_step_count", 32'(step_count), de.stepCount);
               checkOutput("done_cycle", cycleNum, de.cycle);
            end
         end
      end
   end

   task automatic pushFire(input logic [N_IN-1:0] d, input logic [N_IN-1:0] s,
                           input logic [N_W-1:0] w, input int cyc);
      fireExp_t e;
      e.data = d; e.sign = s; e.weight = w; e.cycle = cyc;
      fireQ.push_back(e);
   endtask

   task automatic pushDone(input int steps, input int cyc);
      doneExp_t e;
      e.stepCount = steps; e.cycle = cyc;
      doneQ.push_back(e);
   endtask

   // Wait to the falling edge of a given cycle.
   task automatic waitCycle(input int target);
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while ((cycleNum < target) && (guard < 2000));
      checkOutput("waitCycle_reached", cycleNum, target);
   endtask

   task automatic waitIdle();
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (busy && (guard < 100));
      checkOutput("waitIdle_busy", 32'(busy), 32'd0);
   endtask

   // Returns with startC = first COLLECT cycle of the run.
   task automatic startRun(input logic [15:0] steps, output int startC);
      num_steps = steps;
      start = 1'b1;
      @(posedge clk);
      #1;
      startC = cycleNum;
      start = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic sendSpike(input int ch, input logic sgn);
      int guard = 0;
      spike_valid[ch] = 1'b1;
      spike_sign[ch]  = sgn;
      @(negedge clk);
      while (!spike_ready[ch] && (guard < 60)) begin
         @(negedge clk);
         guard++;
      end
      if (!spike_ready[ch]) begin
         numChecks++;
         numFails++;
         $display("[TB] FAIL spike_accept_timeout: channel %0d never ready", ch);
         spike_valid[ch] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         spike_valid[ch] = 1'b0;
         spike_sign[ch]  = 1'b0;
      end
   endtask

   task automatic sendCfg(input logic [N_W-1:0] w, output int acceptCycle);
      int guard = 0;
      cfg_valid  = 1'b1;
      cfg_weight = w;
      @(negedge clk);
      while (!cfg_ready && (guard < 60)) begin
         @(negedge clk);
         guard++;
      end
      if (!cfg_ready) begin
         numChecks++;
         numFails++;
         $display("[TB] FAIL cfg_accept_timeout: cfg_ready never high");
         acceptCycle = cycleNum;
      end else begin
         @(posedge clk);
         #1;
         acceptCycle = cycleNum - 1;
      end
      cfg_valid  = 1'b0;
      cfg_weight = '0;
   endtask

   task automatic applyStimulus();
      int sc;
      int acc;

      // Reset values while reset is held and just after release.
      repeat (2) @(negedge clk);
      checkOutput("rst_data_in", 32'(data_in), 32'd0);
      checkOutput("rst_sign_in", 32'(sign_in), 32'd0);
      checkOutput("rst_weight", 32'(weight), 32'd0);
      checkOutput("rst_spike_ready", 32'(spike_ready), 32'd0);
      checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      checkOutput("rst_spike_cnt", 32'(spike_cnt), 32'd0);
      checkOutput("rst_step_count", 32'(step_count), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_spike_ready", 32'(spike_ready), 32'd0);

      // Three-step run, one ch0 spike per step, fires 13 cycles apart.
      $display("[TB] three-step run on ch0");
      startRun(16'd3, sc);
      pushFire(3'b001, 3'b001, 5'b00000, sc + COLL);
      sendSpike(0, 1'b1);
      pushFire(3'b001, 3'b000, 5'b00000, sc + COLL + STEP);
      sendSpike(0, 1'b0);
      pushFire(3'b001, 3'b001, 5'b00000, sc + COLL + 2*STEP);
      pushDone(3, sc + 3*STEP);
      sendSpike(0, 1'b1);
      waitIdle();
      checkOutput("run3_step_count", 32'(step_count), 32'd3);

      // Back-to-back requests on ch1: second waits for the next step.
      $display("[TB] back-to-back ch1");
      startRun(16'd2, sc);
      pushFire(3'b010, 3'b000, 5'b00000, sc + COLL);
      pushFire(3'b010, 3'b010, 5'b00000, sc + COLL + STEP);
      pushDone(2, sc + 2*STEP);
      sendSpike(1, 1'b0);
      spike_valid[1] = 1'b1;
      spike_sign[1]  = 1'b1;
      @(negedge clk);
      checkOutput("ch1_held_ready", 32'(spike_ready[1]), 32'd0);
      @(posedge clk);
      #1;
      sendSpike(1, 1'b1);
      waitIdle();

      // Weight update during COLLECT lands the cycle after FIRE.
      $display("[TB] weight update in COLLECT");
      startRun(16'd1, sc);
      pushFire(3'b100, 3'b100, 5'b00000, sc + COLL);
      pushDone(1, sc + STEP);
      sendCfg(5'b11001, acc);
      @(negedge clk);
      checkOutput("cfg_ready_shadow_full", 32'(cfg_ready), 32'd0);
      @(posedge clk);
      #1;
      sendSpike(2, 1'b1);
      waitCycle(sc + COLL);
      checkOutput("weight_during_fire", 32'(weight), 32'h00);
      waitCycle(sc + COLL + 1);
      checkOutput("weight_after_fire", 32'(weight), 32'h19);
      checkOutput("cfg_ready_after_copy", 32'(cfg_ready), 32'd1);
      waitIdle();

      // Output counter saturation on output 0 over a free run.
      $display("[TB] counter saturation");
      startRun(16'd0, sc);
      out_data = 2'b01;
      waitCycle(sc + 100);
      checkOutput("spike_cnt_100", 32'(spike_cnt), 32'h0064);
      waitCycle(sc + 300);
      pushDone(24, sc + 24*STEP);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      waitIdle();
      out_data = 2'b00;
      checkOutput("spike_cnt_sat", 32'(spike_cnt), 32'h00FF);

      // Free run stopped mid-COLLECT of step 5.
      $display("[TB] free run stopped in step 5");
      startRun(16'd0, sc);
      waitCycle(sc + 4*STEP + 4);
      pushDone(5, sc + 5*STEP);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      waitIdle();
      checkOutput("stop_step_count", 32'(step_count), 32'd5);

      // Reset in SETTLE with slots full and the shadow loaded.
      $display("[TB] reset mid-SETTLE");
      startRun(16'd0, sc);
      waitCycle(sc + COLL + 1);
      cfg_valid   = 1'b1;
      cfg_weight  = 5'b10101;
      spike_valid = 3'b011;
      spike_sign  = 3'b011;
      @(posedge clk);
      #1;
      cfg_valid   = 1'b0;
      cfg_weight  = '0;
      spike_valid = '0;
      spike_sign  = '0;
      @(negedge clk);
      checkOutput("pre_rst_cfg_ready", 32'(cfg_ready), 32'd0);
      checkOutput("pre_rst_spike_ready", 32'(spike_ready), 32'b100);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midrst_weight", 32'(weight), 32'd0);
      checkOutput("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
      checkOutput("midrst_spike_ready", 32'(spike_ready), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_step_count", 32'(step_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      startRun(16'd0, sc);
      @(negedge clk);
      checkOutput("postrst_slots_empty", 32'(spike_ready), 32'b111);
      waitCycle(sc + COLL + 1);
      checkOutput("postrst_shadow_dropped", 32'(weight), 32'd0);
      pushDone(1, sc + STEP);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      waitIdle();

      // Weight update in IDLE applies right after acceptance.
      $display("[TB] weight update in IDLE");
      @(posedge clk);
      #1;
      sendCfg(5'b00110, acc);
      waitCycle(acc + 2);
      checkOutput("idle_weight_update", 32'(weight), 32'h06);

      repeat (3) @(negedge clk);
      checkOutput("fireQ_drained", fireQ.size(), 32'd0);
      checkOutput("doneQ_drained", doneQ.size(), 32'd0);
   endtask

   initial begin
      applyStimulus();
      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/snn_step_controller.md
# snn_step_controller

Time-step sequencer for the 3-input/2-output spiking network. Accepts asynchronous-rate spike requests from upstream sources through per-channel valid/ready handshakes, and emits them to the network as clean, clock-aligned one-cycle `data_in`/`sign_in` pulses once per time step. Holds the network weights, applying reconfiguration only at step boundaries. Counts output spikes over a run of a programmed number of steps.

## Interface
Parameters:
- `N_IN`, 3, network input channels
- `N_OUT`, 2, network output neurons
- `N_W`, 5, weight bits
- `COLLECT_CYCLES`, 8, cycles per step in which spikes are accepted (≥1)
- `SETTLE_CYCLES`, 4, cycles after the fire pulse for network outputs (≥1)
- `CNT_W`, 8, output spike counter width
- `WEIGHT_RST`, 5'b00000, weight value after reset

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  run request, sampled in IDLE only
- `stop`  in  1  end run after the current step; sticky until DONE
- `num_steps`  in  16  steps per run, sampled at start; 0 = run until stop
- `spike_valid`  in  N_IN  per-channel spike request
- `spike_sign`  in  N_IN  sign for that request
- `spike_ready`  out  N_IN  per-channel accept
- `cfg_valid`  in  1  weight update request
- `cfg_weight`  in  N_W  new weights
- `cfg_ready`  out  1  shadow register empty
- `data_in`  out  N_IN  spike pulses to network
- `sign_in`  out  N_IN  sign pulses to network
- `weight`  out  N_W  weights to network
- `out_data`  in  N_OUT  network output spikes
- `spike_cnt`  out  N_OUT*CNT_W  per-output spike counts, output 0 in LSBs
- `step_count`  out  16  completed steps in current/last run
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse at end of run

## Operation
- FSM: IDLE, COLLECT, FIRE, SETTLE, DONE.
- IDLE: `start`=1 → COLLECT; clears `step_count`, `spike_cnt`, stop flag; latches `num_steps`.
- COLLECT: lasts exactly COLLECT_CYCLES; then FIRE.
- FIRE: one cycle; `data_in` = pending bits, `sign_in` = pending bits AND captured signs; all pending slots cleared at end of cycle.
- SETTLE: SETTLE_CYCLES; last cycle increments `step_count`; next state DONE if stop flag set or (`num_steps`≠0 and new count = `num_steps`), else COLLECT.
- DONE: `done`=1 one cycle → IDLE. Counters hold until next `start`.
- Spike slot per channel: one entry. `spike_ready[i]` = slot empty AND state ∈ {COLLECT, SETTLE}. Transfer on valid & ready. Full slot: ready=0; upstream holds. Second spike on same channel in one step waits for next step. Spikes accepted during SETTLE fire in the next step.
- Weights: `cfg_ready` = shadow empty, in any state. Shadow copied to `weight` at the end of FIRE, or in IDLE immediately the cycle after acceptance. `weight` never changes in a cycle where `data_in`≠0.
- Output counting: during COLLECT, FIRE, SETTLE, `spike_cnt[j]` += `out_data[j]`, saturating at all-ones. Ignored in IDLE/DONE.
- `stop` in IDLE ignored. `start` while busy ignored.
- `num_steps` = 0: free-run; `step_count` wraps at 16'hFFFF→0.

## Timing
- Reset: state IDLE, `data_in`/`sign_in`=0, `weight`=WEIGHT_RST, `spike_ready`=0, `cfg_ready`=1, `spike_cnt`/`step_count`=0, `busy`/`done`=0, slots and shadow empty.
- Step length = COLLECT_CYCLES + 1 + SETTLE_CYCLES cycles.
- `start` at edge k → COLLECT from k+1; first FIRE at cycle k+1+COLLECT_CYCLES.
- All outputs registered; `data_in`/`sign_in` exactly one cycle wide.
- Reset mid-run: immediate return to reset values; pending spikes and shadow discarded.

## Structure
- Package `snn_ctrl_pkg`: state enum, default parameter constants, counter widths.
- Sub-module `snn_spike_slot`: one-entry valid/ready holding register (data+sign) with clear; instantiated N_IN times.

## Test plan
- Reset mid-SETTLE with slots full and weight shadowed → all outputs at reset values next cycle, `weight`=WEIGHT_RST.
- `num_steps`=3, default timing, spike on ch0 each step → three `data_in`=3'b001 pulses 13 cycles apart, `step_count`=3, `done` pulses once.
- Two back-to-back valids on ch1 in one COLLECT → first fires step 1, second held (ready=0) then fires step 2.
- `cfg_valid` with 5'b11001 during COLLECT → `weight` changes the cycle after FIRE, not before.
- `out_data`=2'b01 held 300 cycles with CNT_W=8 → `spike_cnt[7:0]`=255 saturates, `spike_cnt[15:8]`=0.
- `num_steps`=0, `stop` asserted mid-COLLECT of step 5 → step 5 completes, `step_count`=5, `done` pulse, IDLE.
